// File: rtl/aes_key_schedule.sv
// AES-128 key schedule. Expands a 128-bit cipher key into round keys 0..NROUNDS,
// writing one round key per clock, and keeps them for random-order readback.
// Ports:
//   clock      - rising-edge clock
//   reset      - asynchronous active-high reset, clears all state and round keys
//   key_valid  - cipher key present on key
//   key        - cipher key, w0 in key[127:96], w3 in key[31:0]
//   key_ready  - a key can be accepted this cycle (IDLE or DONE)
//   done       - all round keys valid
//   rk_index   - round-key read select
//   rk_out     - round key rk[rk_index] (combinational), zero for indices above NROUNDS
module aes_key_schedule #(
    parameter int unsigned NROUNDS = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         key_valid,
    input  logic [127:0] key,
    output logic         key_ready,
    output logic         done,
    input  logic [3:0]   rk_index,
    output logic [127:0] rk_out
);

    localparam int unsigned KW = 128;
    localparam int unsigned RW = 4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [RW-1:0] round;
    logic [KW-1:0] rk [0:NROUNDS];

    logic          accept_c;
    logic [KW-1:0] prev_c;
    logic [KW-1:0] next_c;
    logic [31:0]   temp_c;
    logic [7:0]    rcon_c;

    assign key_ready = (state != S_EXPAND);
    assign accept_c  = key_valid && key_ready;

    // Round constant for the round key being written.
    always_comb begin
        rcon_c = 8'h00;
        case (round)
            4'd1:    rcon_c = 8'h01;
            4'd2:    rcon_c = 8'h02;
            4'd3:    rcon_c = 8'h04;
            4'd4:    rcon_c = 8'h08;
            4'd5:    rcon_c = 8'h10;
            4'd6:    rcon_c = 8'h20;
            4'd7:    rcon_c = 8'h40;
            4'd8:    rcon_c = 8'h80;
            4'd9:    rcon_c = 8'h1b;
            4'd10:   rcon_c = 8'h36;
            default: rcon_c = 8'h00;
        endcase
    end

    // Previous round key rk[round-1]; zero when round is outside 1..NROUNDS.
    always_comb begin
        prev_c = '0;
        for (int unsigned i = 0; i < NROUNDS; i++) begin
            if (round == RW'(i + 1)) begin
                prev_c = rk[i];
            end
        end
    end

    // One key-expansion step: SubWord(RotWord(w3)) ^ Rcon, then the XOR chain.
    always_comb begin
        temp_c = {SBOX[prev_c[23:16]], SBOX[prev_c[15:8]], SBOX[prev_c[7:0]], SBOX[prev_c[31:24]]}
                 ^ {rcon_c, 24'h0};
        next_c[127:96] = prev_c[127:96] ^ temp_c;
        next_c[95:64]  = prev_c[95:64]  ^ next_c[127:96];
        next_c[63:32]  = prev_c[63:32]  ^ next_c[95:64];
        next_c[31:0]   = prev_c[31:0]   ^ next_c[63:32];
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept_c) state_next = S_EXPAND;
            S_EXPAND: if (round == RW'(NROUNDS)) state_next = S_DONE;
            S_DONE:   if (accept_c) state_next = S_EXPAND;
            default:  state_next = S_IDLE;
        endcase
    end

    // Round counter and done flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            round <= '0;
            done  <= 1'b0;
        end else if (accept_c) begin
            round <= RW'(1);
            done  <= 1'b0;
        end else if (state == S_EXPAND) begin
            round <= round + RW'(1);
            if (round == RW'(NROUNDS)) begin
                done <= 1'b1;
            end
        end
    end

    // Round-key storage: rk[0] on acceptance, then one entry per EXPAND cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i <= NROUNDS; i++) begin
                rk[i] <= '0;
            end
        end else if (accept_c) begin
            rk[0] <= key;
        end else if (state == S_EXPAND) begin
            for (int unsigned i = 1; i <= NROUNDS; i++) begin
                if (round == RW'(i)) begin
                    rk[i] <= next_c;
                end
            end
        end
    end

    // Read port; indices above NROUNDS return zero.
    always_comb begin
        rk_out = '0;
        for (int unsigned i = 0; i <= NROUNDS; i++) begin
            if (rk_index == RW'(i)) begin
                rk_out = rk[i];
            end
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: a word-level FIPS-197 key expansion
// model (S-box derived from GF(2^8) inverse + affine map) tracks the expected
// outputs, compared every cycle, plus literal FIPS-197 vectors.
module tb_aes_key_schedule;

    typedef logic [127:0] sched_t [0:10];

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clock = 1'b0;
    logic         reset;
    logic         key_valid = 1'b0;
    logic [127:0] key = '0;
    logic         key_ready;
    logic         done;
    logic [3:0]   rk_index = '0;
    logic [127:0] rk_out;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic [7:0] sb [0:255];

    sched_t m_rk;
    sched_t m_tgt;
    bit     m_busy = 1'b0;
    bit     m_done = 1'b0;
    int     m_cnt  = 0;

    aes_key_schedule #(.NROUNDS(10)) dut (
        .clock     (clock),
        .reset     (reset),
        .key_valid (key_valid),
        .key       (key),
        .key_ready (key_ready),
        .done      (done),
        .rk_index  (rk_index),
        .rk_out    (rk_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Textbook 44-word expansion.
    task automatic expand_key(input logic [127:0] k, output sched_t s);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) s[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    // Behavioural model: full schedule computed at acceptance, revealed one entry per edge.
    always @(posedge clock or posedge reset) begin : model
        sched_t s;
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            for (int i = 0; i < 11; i++) m_rk[i] <= '0;
        end else if (m_busy) begin
            m_rk[m_cnt] <= m_tgt[m_cnt];
            m_cnt       <= m_cnt + 1;
            if (m_cnt == 10) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end
        end else if (key_valid) begin
            expand_key(key, s);
            m_tgt  <= s;
            m_rk[0] <= key;
            m_cnt  <= 1;
            m_busy <= 1'b1;
            m_done <= 1'b0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check("key_ready", 128'(key_ready), 128'(!m_busy));
            check("done", 128'(done), 128'(m_done));
            check("rk_out", rk_out, (rk_index <= 4'd10) ? m_rk[rk_index] : 128'h0);
        end
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic load_key(input logic [127:0] k);
        key       = k;
        key_valid = 1'b1;
        @(posedge clock);
        #1;
        key_valid = 1'b0;
        key       = rand128();
    endtask

    // Waits for done after an acceptance edge; returns edges counted from acceptance.
    task automatic wait_done(output int edges);
        edges = 1;
        while (!done && edges < 40) begin
            @(posedge clock);
            #1;
            edges++;
            rk_index = 4'($urandom_range(0, 15));
        end
        check("done_seen", 128'(done), 128'(1));
    endtask

    task automatic read_check(input string name, input logic [3:0] idx, input logic [127:0] exp);
        rk_index = idx;
        @(negedge clock);
        check(name, rk_out, exp);
        @(posedge clock);
        #1;
    endtask

    initial begin
        sched_t s_fips;
        sched_t s_zero;
        sched_t s_a;
        logic [127:0] ka;
        int edges;

        reset = 1'b1;
        build_sbox();

        // Pin the model against literal FIPS-197 values.
        check("sbox_00", 128'(sb[0]), 128'h63);
        check("sbox_53", 128'(sb[8'h53]), 128'hed);
        check("sbox_ff", 128'(sb[255]), 128'h16);
        expand_key(FIPS_KEY, s_fips);
        check("model_fips_rk1", s_fips[1], FIPS_RK1);
        check("model_fips_rk10", s_fips[10], FIPS_RK10);
        expand_key('0, s_zero);
        check("model_zero_rk1", s_zero[1], ZERO_RK1);
        check("model_zero_rk10", s_zero[10], ZERO_RK10);

        chk_en = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        // Key accepted on the first edge after reset release.
        reset = 1'b0;
        load_key(FIPS_KEY);
        wait_done(edges);
        check("fips_edges", 128'(edges), 128'd11);
        read_check("fips_rk0", 4'd0, FIPS_KEY);
        read_check("fips_rk1", 4'd1, FIPS_RK1);
        read_check("fips_rk10", 4'd10, FIPS_RK10);

        // All-zero key.
        load_key('0);
        wait_done(edges);
        check("zero_edges", 128'(edges), 128'd11);
        read_check("zero_rk0", 4'd0, 128'h0);
        read_check("zero_rk1", 4'd1, ZERO_RK1);
        read_check("zero_rk10", 4'd10, ZERO_RK10);

        // Second key_valid pulse mid-expansion is ignored.
        ka = rand128();
        expand_key(ka, s_a);
        load_key(ka);
        repeat (3) @(posedge clock);
        #1;
        key       = ~ka;
        key_valid = 1'b1;
        @(negedge clock);
        check("busy_key_ready", 128'(key_ready), 128'(0));
        @(posedge clock);
        #1;
        key_valid = 1'b0;
        wait_done(edges);
        read_check("ignored_rk10", 4'd10, s_a[10]);

        // Reset five edges into expansion.
        load_key(FIPS_KEY);
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rk_index = 4'(i);
            @(negedge clock);
            check("reset_rk_zero", rk_out, 128'h0);
        end
        check("reset_done", 128'(done), 128'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_ready", 128'(key_ready), 128'(1));
        @(posedge clock);
        #1;
        load_key(FIPS_KEY);
        wait_done(edges);
        check("refips_edges", 128'(edges), 128'd11);
        read_check("refips_rk1", 4'd1, FIPS_RK1);
        read_check("refips_rk10", 4'd10, FIPS_RK10);

        // Back-to-back: random key, then FIPS key accepted in DONE.
        load_key(rand128());
        wait_done(edges);
        load_key(FIPS_KEY);
        @(negedge clock);
        check("b2b_done_drop", 128'(done), 128'(0));
        wait_done(edges);
        check("b2b_edges", 128'(edges), 128'd11);
        for (int i = 10; i >= 0; i--) read_check("desc_sweep", 4'(i), s_fips[i]);
        for (int i = 11; i < 16; i++) read_check("high_index", 4'(i), 128'h0);

        // Randomized traffic: keys, stray key_valid, random reads and resets.
        for (int c = 0; c < 600; c++) begin
            key_valid = ($urandom_range(0, 3) == 0);
            key       = rand128();
            rk_index  = 4'($urandom_range(0, 15));
            reset     = ($urandom_range(0, 79) == 0);
            @(posedge clock);
            #1;
        end
        reset     = 1'b0;
        key_valid = 1'b0;
        @(posedge clock);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
